// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with valid/ready handshake, 2-entry skid, flush and starvation counter
module pipe_stage_skid #(
  parameter int          DATA_W   = 96,
  parameter int          CTRL_W   = 16,
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  starve_cnt
);

  logic              out_v;
  logic              skid_v;
  logic [31:0]       skid_instr;
  logic [PC_W-1:0]   skid_pc;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              accept;
  logic              drain;
  logic              is_nop;
  logic [CTRL_W-1:0] sq_ctrl;
  logic [DATA_W-1:0] sq_data;

  // in_ready comes straight from the skid valid flop, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_v;
  assign out_valid = out_v;

  assign accept  = in_valid & in_ready & ~flush;
  assign drain   = out_v & out_ready;
  assign is_nop  = (in_instr == NOP_WORD);
  assign sq_ctrl = is_nop ? '0 : in_ctrl;
  assign sq_data = is_nop ? '0 : in_data;

  // Output/skid state machine over {out_v, skid_v}; flush wins over every transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v      <= 1'b0;
      skid_v     <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_v     <= 1'b0;
      skid_v    <= 1'b0;
      out_instr <= NOP_WORD;
      out_pc    <= in_pc;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (!out_v) begin
      if (accept) begin
        out_v     <= 1'b1;
        out_instr <= in_instr;
        out_pc    <= in_pc;
        out_ctrl  <= sq_ctrl;
        out_data  <= sq_data;
      end
    end else if (!skid_v) begin
      if (drain) begin
        if (accept) begin
          out_instr <= in_instr;
          out_pc    <= in_pc;
          out_ctrl  <= sq_ctrl;
          out_data  <= sq_data;
        end else begin
          // going empty: clear enables so nothing stale is visible downstream
          out_v    <= 1'b0;
          out_ctrl <= '0;
          out_data <= '0;
        end
      end else if (accept) begin
        skid_v     <= 1'b1;
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
        skid_ctrl  <= sq_ctrl;
        skid_data  <= sq_data;
      end
    end else if (drain) begin
      skid_v    <= 1'b0;
      out_instr <= skid_instr;
      out_pc    <= skid_pc;
      out_ctrl  <= skid_ctrl;
      out_data  <= skid_data;
    end
  end

  // Saturating count of cycles where downstream was ready but nothing was offered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (cnt_clr) begin
      starve_cnt <= '0;
    end else if (out_ready && !out_v && (starve_cnt != {CNT_W{1'b1}})) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
